// File: rtl/pwm_pkg.sv
// Shared definitions for the pulse width meter and its m/n waveform generator.
package pwm_pkg;

  localparam int PWM_WIDTH = 4;
  localparam logic [PWM_WIDTH-1:0] CNT_MAX = {PWM_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } pwm_state_t;

endpackage

// File: rtl/pulse_width_meter_edge_detect.sv
// Sampling front end: optional two-flop synchronizer, previous-sample register and rise detect.
// With PULSE_WIDTH_METER_SYNC_EN defined, din is synchronized before edge detection (2 cycles extra latency).
module edge_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_din,
  output logic o_s,
  output logic o_rise
);

  logic w_s;
  logic r_din_prev;

`ifdef PULSE_WIDTH_METER_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  // Flops reset high so a line already high at reset never looks like a rising edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_din;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2;
`else
  assign w_s = i_din;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_din_prev <= 1'b1;
    else       r_din_prev <= w_s;
  end

  assign o_s    = w_s;
  assign o_rise = w_s & ~r_din_prev;

endmodule

// File: rtl/pulse_width_meter.sv
// Measures each complete high phase and the following low phase of din and reports them with a valid strobe.
// Optional input synchronizer selected by PULSE_WIDTH_METER_SYNC_EN (see edge_detect).
//   state | meaning
//   IDLE  | waiting for the first rising edge; the partial period after reset is discarded
//   HIGH  | counting high samples into hi_cnt
//   LOW   | counting low samples into lo_cnt; the next rise reports and restarts
module pulse_width_meter
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  output logic [WIDTH-1:0] m_out,
  output logic [WIDTH-1:0] n_out,
  output logic             valid,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] C_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

  logic w_s;
  logic w_rise;

  pwm_state_t       r_state,    w_state_nxt;
  logic [WIDTH-1:0] r_hi_cnt,   w_hi_cnt_nxt;
  logic [WIDTH-1:0] r_lo_cnt,   w_lo_cnt_nxt;
  logic             r_ovf,      w_ovf_nxt;
  logic [WIDTH-1:0] r_m_out,    w_m_out_nxt;
  logic [WIDTH-1:0] r_n_out,    w_n_out_nxt;
  logic             r_overflow, w_overflow_nxt;
  logic             r_valid,    w_valid_nxt;

  edge_detect u_edge_detect (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_din  (din),
    .o_s    (w_s),
    .o_rise (w_rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_hi_cnt   <= '0;
      r_lo_cnt   <= '0;
      r_ovf      <= 1'b0;
      r_m_out    <= '0;
      r_n_out    <= '0;
      r_overflow <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hi_cnt   <= w_hi_cnt_nxt;
      r_lo_cnt   <= w_lo_cnt_nxt;
      r_ovf      <= w_ovf_nxt;
      r_m_out    <= w_m_out_nxt;
      r_n_out    <= w_n_out_nxt;
      r_overflow <= w_overflow_nxt;
      r_valid    <= w_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_hi_cnt_nxt   = r_hi_cnt;
    w_lo_cnt_nxt   = r_lo_cnt;
    w_ovf_nxt      = r_ovf;
    w_m_out_nxt    = r_m_out;
    w_n_out_nxt    = r_n_out;
    w_overflow_nxt = r_overflow;
    w_valid_nxt    = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_state_nxt  = HIGH;
          w_hi_cnt_nxt = C_ONE;
          w_ovf_nxt    = 1'b0;
        end
      end
      HIGH: begin
        if (w_s) begin
          // Counters stick at max; any attempted step past it flags the pair.
          if (r_hi_cnt == C_MAX) w_ovf_nxt    = 1'b1;
          else                   w_hi_cnt_nxt = r_hi_cnt + C_ONE;
        end else begin
          w_state_nxt  = LOW;
          w_lo_cnt_nxt = C_ONE;
        end
      end
      LOW: begin
        if (!w_s) begin
          if (r_lo_cnt == C_MAX) w_ovf_nxt    = 1'b1;
          else                   w_lo_cnt_nxt = r_lo_cnt + C_ONE;
        end else begin
          w_m_out_nxt    = r_hi_cnt;
          w_n_out_nxt    = r_lo_cnt;
          w_overflow_nxt = r_ovf;
          w_valid_nxt    = 1'b1;
          w_state_nxt    = HIGH;
          w_hi_cnt_nxt   = C_ONE;
          w_ovf_nxt      = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign m_out    = r_m_out;
  assign n_out    = r_n_out;
  assign valid    = r_valid;
  assign overflow = r_overflow;

endmodule

// File: doc/pulse_width_meter.md
Name: pulse_width_meter

Overview:
Receive-side counterpart of the m/n waveform generator. That generator drives `out` high for m clocks, then low for n clocks, repeating.
- This block samples a single-bit waveform `din`.
- It measures the length of each complete high phase and the low phase that follows it, in clock cycles.
- It reports the measured pair (m_out, n_out) with a one-cycle `valid` strobe.
- It sits in the self-check loop: generator `out` feeds `din`, and the reported values must equal the programmed m/n.

Parameters:
- WIDTH, 4, width of the count fields (matches the generator's 4-bit m/n).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- din  input  1  waveform under measurement.
- m_out  output  WIDTH  length of the last complete high phase, in cycles.
- n_out  output  WIDTH  length of the last complete low phase, in cycles.
- valid  output  1  one-cycle strobe; m_out/n_out/overflow were updated this cycle.
- overflow  output  1  reported pair contains a saturated count; same timing as m_out/n_out.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values: state=IDLE; hi_cnt, lo_cnt, m_out, n_out = 0; valid = 0; overflow = 0; ovf flag = 0; din_prev = 1.
  - din_prev resets to 1 so that din already high at reset is not taken as a rising edge.
- Sampled input: s = din (with SYNC_EN: s = synchronizer output). rise = s & ~din_prev. din_prev <= s every cycle.
- FSM states: IDLE, HIGH, LOW.
  - IDLE: wait for rise. On rise: go to HIGH, hi_cnt <= 1, ovf <= 0. The first partial period after reset is never reported.
  - HIGH, s=1: hi_cnt <= hi_cnt+1, saturating at 2^WIDTH-1. Any attempted increment past max sets ovf.
  - HIGH, s=0: go to LOW, lo_cnt <= 1.
  - LOW, s=0: lo_cnt <= lo_cnt+1, saturating, same ovf rule.
  - LOW, s=1 (rise): report and restart in a single cycle.
    - m_out <= hi_cnt, n_out <= lo_cnt, overflow <= ovf, valid <= 1.
    - Go to HIGH, hi_cnt <= 1, ovf <= 0.
- valid is high for exactly one cycle per complete high+low period. It deasserts on the next clock unless another report occurs, which requires m,n ≥ 1, so back-to-back strobes are impossible.
- Latency: valid rises on the clock edge after the first high sample of the next period.
- m_out/n_out/overflow hold their last reported values between strobes.
- Count semantics: a phase of k samples reports k. Minimum reportable value is 1; 0 is never reported.
- Saturation: a phase longer than 2^WIDTH-1 cycles reports 2^WIDTH-1 with overflow=1. Overflow in either phase flags the pair.
- Constant din (never toggles): no report. IDLE remains, or HIGH/LOW remain with a saturated counter; no wrap-around ever.
- Reset mid-measurement: counts discarded, outputs cleared, back to IDLE. The next report requires a full fresh period.

Optional Feature:
- Macro: PULSE_WIDTH_METER_SYNC_EN.
- Defined: din passes through a two-flop synchronizer (both flops reset to 1) before edge detection.
  - Adds 2 cycles to report latency.
  - Measured widths are unchanged.
- Undefined: din is sampled directly. din is assumed to be synchronous to clk.

Decomposition:
- Shared package pwm_pkg:
  - PWM_WIDTH = 4 (shared with the generator).
  - State typedef/localparams: IDLE=2'd0, HIGH=2'd1, LOW=2'd2.
  - Saturation constant CNT_MAX = 2^WIDTH-1.
- One natural sub-module: edge_detect (optional synchronizer + din_prev register + rise output).
- The FSM, counters and output registers stay in the top.

Test Plan:
- Generator loop, m=5, n=3, reset released at t=5 clocks:
  - First valid appears after one discarded partial period.
  - Then valid every 8 cycles with m_out=5, n_out=3, overflow=0.
- din held high through reset and 20 cycles, then low 4, high 2, low 6, high:
  - No report for the leading high, since no rising edge was seen.
  - Single report m_out=2, n_out=6.
- din high 20 cycles, low 3, then rise (WIDTH=4):
  - m_out=15, n_out=3, overflow=1.
  - Next normal period (m=2, n=2) reports overflow=0.
- Minimum widths, alternating 1 high / 1 low:
  - Reports m_out=1, n_out=1 every 2 cycles.
  - valid is a single-cycle pulse each time.
- Assert rst during LOW of a 5/3 stream, release 2 cycles later:
  - Outputs 0 immediately (async).
  - No report until one full post-reset period.
  - Then 5/3 again.
- With PULSE_WIDTH_METER_SYNC_EN defined, repeat scenario 1:
  - Identical values.
  - valid shifted 2 cycles later.
